// File: rtl/mssd_pkg.sv
// mssd_pkg: shared types and constants for the mssd front end
package mssd_pkg;
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } pb_state_t;
   localparam int PB_DB_DEFAULT  = 500000;
   localparam int PB_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit multi-flop synchronizer with synchronous reset to 0
module sync_2ff
   import mssd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [PB_SYNC_STAGES-1:0] sync_q;
   // shift the asynchronous level through the synchronizer chain
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[PB_SYNC_STAGES-2:0], d_i};
   end
   assign q_o = sync_q[PB_SYNC_STAGES-1];
endmodule

// File: rtl/pb_serial_sampler.sv
// pb_serial_sampler: debounced push-button strobe with serial bit capture (optional PB_PRESS_COUNT_EN adds press_count)
module pb_serial_sampler
   import mssd_pkg::*;
#(
   parameter int DB_CYCLES = PB_DB_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clkPB,
   input  logic       SerIn,
`ifdef PB_PRESS_COUNT_EN
   output logic [7:0] press_count,
`endif
   output logic       bit_valid,
   output logic       bit_data,
   output logic       pb_level
);
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DB_CYCLES);
   logic             pb_s, ser_s;
   pb_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             cap_q, cap_d;
   logic             fire;
   logic             bit_valid_q, bit_data_q;
   sync_2ff u_sync_pb  (.clk(clk), .rst(rst), .d_i(clkPB), .q_o(pb_s));
   sync_2ff u_sync_ser (.clk(clk), .rst(rst), .d_i(SerIn), .q_o(ser_s));
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
   // debounce FSM: a strobe fires only on the PRESS_WAIT -> PRESSED edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      fire    = 1'b0;
      case (state_q)
         IDLE: if (pb_s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
            cap_d   = ser_s;
         end
         PRESS_WAIT: if (!pb_s) state_d = IDLE;
            else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               fire    = 1'b1;
            end else cnt_d = cnt_inc;
         PRESSED: if (!pb_s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
         end
         RELEASE_WAIT: if (pb_s) state_d = PRESSED;
            else if (cnt_q == CNT_LAST) state_d = IDLE;
            else cnt_d = cnt_inc;
         default: state_d = IDLE;
      endcase
   end
   // state, counter, capture and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cap_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         bit_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_q       <= cap_d;
         bit_valid_q <= fire;
         bit_data_q  <= fire ? cap_q : bit_data_q;
      end
   end
   assign bit_valid = bit_valid_q;
   assign bit_data  = bit_data_q;
   assign pb_level  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
`ifdef PB_PRESS_COUNT_EN
   logic [7:0] press_count_q;
   // count accepted presses, wrapping at 256
   always_ff @(posedge clk) begin
      if (rst) press_count_q <= '0;
      else     press_count_q <= press_count_q + {7'd0, fire};
   end
   assign press_count = press_count_q;
`endif
endmodule

// File: tb/tb_pb_serial_sampler.sv
// tb_pb_serial_sampler: directed self-checking bench for pb_serial_sampler (DB_CYCLES=4)
module tb_pb_serial_sampler;
   localparam int DB = 4;
   logic clk = 1'b0, rst = 1'b1, clkPB = 1'b0, SerIn = 1'b0;
   logic bit_valid, bit_data, pb_level;
`ifdef PB_PRESS_COUNT_EN
   logic [7:0] press_count;
`endif
   int   vectors = 0, miscompares = 0, strobes = 0, s0;
   logic last_data = 1'b0, prev_valid = 1'b0;

   always #10 clk = ~clk;

   pb_serial_sampler #(.DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .clkPB(clkPB), .SerIn(SerIn),
`ifdef PB_PRESS_COUNT_EN
      .press_count(press_count),
`endif
      .bit_valid(bit_valid), .bit_data(bit_data), .pb_level(pb_level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic press(input logic d, input int hi, input int lo);
      SerIn = d;
      clkPB = 1'b1;
      tick(hi);
      clkPB = 1'b0;
      tick(lo);
   endtask

   // strobe monitor: count pulses, remember their data, flag pulses wider than one cycle
   always @(negedge clk) begin
      if (bit_valid === 1'b1) begin
         strobes++;
         last_data = bit_data;
         check("strobe_width", {31'd0, prev_valid}, 0);
      end
      prev_valid = (bit_valid === 1'b1);
   end

   initial begin
      rst = 1'b1; clkPB = 1'b1; SerIn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         check("reset_outs", {29'd0, bit_valid, bit_data, pb_level}, 0);
      end
      rst = 1'b0;
      tick(1);
      check("rst_fall_bv", bit_valid, 0);
      tick(5);
      check("post_rst_bv_e5", bit_valid, 0);
      tick(1);
      check("post_rst_bv_e6", bit_valid, 1);
      check("post_rst_bd", bit_data, 1);
      clkPB = 1'b0;
      tick(10);

      s0 = strobes;
      SerIn = 1'b1; clkPB = 1'b1;
      tick(6);
      check("clean_bv_early", bit_valid, 0);
      check("clean_pl_early", pb_level, 0);
      tick(1);
      check("clean_bv", bit_valid, 1);
      check("clean_bd", bit_data, 1);
      check("clean_pl", pb_level, 1);
      tick(1);
      check("clean_bv_after", bit_valid, 0);
      check("clean_pl_hold", pb_level, 1);
      tick(12);
      clkPB = 1'b0;
      tick(6);
      check("release_pl_hold", pb_level, 1);
      tick(1);
      check("release_pl_drop", pb_level, 0);
      check("clean_count", strobes - s0, 1);
      tick(3);

      s0 = strobes;
      clkPB = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) clkPB = 1'b0;
         tick(1);
         check("glitch_outs", {30'd0, bit_valid, pb_level}, 0);
      end
      check("glitch_count", strobes - s0, 0);

      s0 = strobes;
      clkPB = 1'b1;
      tick(4);
      rst = 1'b1; clkPB = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(8);
      check("rst_mid_count", strobes - s0, 0);
      check("rst_mid_pl", pb_level, 0);

      s0 = strobes;
      SerIn = 1'b1;
      clkPB = 1'b1; tick(1);
      clkPB = 1'b0; tick(1);
      clkPB = 1'b1; tick(1);
      clkPB = 1'b0; tick(1);
      clkPB = 1'b1; tick(20);
      check("bounce_press_count", strobes - s0, 1);
      check("bounce_press_bd", last_data, 1);
      check("bounce_press_pl", pb_level, 1);
      clkPB = 1'b0; tick(1);
      clkPB = 1'b1; tick(1);
      clkPB = 1'b0; tick(12);
      check("bounce_release_count", strobes - s0, 1);
      check("bounce_release_pl", pb_level, 0);

      s0 = strobes;
      SerIn = 1'b0; clkPB = 1'b1;
      tick(2);
      SerIn = 1'b1;
      tick(10);
      check("capture_count", strobes - s0, 1);
      check("capture_bd", last_data, 0);
      clkPB = 1'b0;
      tick(10);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
`ifdef PB_PRESS_COUNT_EN
      check("pc_reset", press_count, 0);
`endif
      s0 = strobes;
      for (int i = 0; i < 40; i++) begin
         press(i[0], 10, 10);
         check("seq_count", strobes - s0, i + 1);
         check("seq_bd", last_data, i % 2);
      end
      check("seq_total", strobes - s0, 40);
`ifdef PB_PRESS_COUNT_EN
      check("pc_40", press_count, 40);
      for (int i = 0; i < 216; i++) press(i[0], 10, 10);
      check("pc_wrap", press_count, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
